// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks the register file and sends each value as 8 hex ASCII chars plus CR LF over an 8N1 UART.
module reg_dump_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;
  state_t state, state_n;
  logic [31:0] snap, snap_n;
  logic [3:0] char_idx, char_n, bit_idx, bit_n;
  logic [BW-1:0] baud, baud_n;
  logic [4:0] sel_n;
  logic busy_n, done_n, tx_n;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  // Frame bit b of character c: start, d0..d7 LSB-first, stop.
  function automatic logic frame_bit(input logic [31:0] s, input logic [3:0] c, input logic [3:0] b);
    logic [3:0] nib;
    logic [7:0] ch;
    nib = 4'(s >> (28 - 4 * int'(c[2:0])));
    ch = c == 4'd8 ? 8'h0D : c == 4'd9 ? 8'h0A : hex(nib);
    return b == 4'd0 ? 1'b0 : b == 4'd9 ? 1'b1 : ch[3'(b - 4'd1)];
  endfunction
  always_comb begin
    state_n = state;
    sel_n = reg_sel;
    busy_n = busy;
    done_n = done;
    snap_n = snap;
    char_n = char_idx;
    bit_n = bit_idx;
    baud_n = baud;
    case (state)
      IDLE: begin
        done_n = 1'b0;
        if (start) begin
          sel_n = 5'd0;
          busy_n = 1'b1;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        snap_n = reg_data;
        char_n = 4'd0;
        bit_n = 4'd0;
        baud_n = '0;
        state_n = SEND;
      end
      SEND: begin
        baud_n = baud == BW'(CLKS_PER_BIT - 1) ? '0 : baud + 1'b1;
        if (baud == BW'(CLKS_PER_BIT - 1)) begin
          bit_n = bit_idx == 4'd9 ? 4'd0 : bit_idx + 4'd1;
          if (bit_idx == 4'd9) begin
            char_n = char_idx == 4'd9 ? 4'd0 : char_idx + 4'd1;
            if (char_idx == 4'd9) begin
              state_n = reg_sel == 5'(NREGS - 1) ? IDLE : CAPTURE;
              sel_n = reg_sel == 5'(NREGS - 1) ? 5'd0 : reg_sel + 5'd1;
              busy_n = reg_sel != 5'(NREGS - 1);
              done_n = reg_sel == 5'(NREGS - 1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // tx is computed from next-state values so the registered output lines up with the bit counters.
    tx_n = state_n == SEND ? frame_bit(snap_n, char_n, bit_n) : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      reg_sel <= 5'd0;
      busy <= 1'b0;
      done <= 1'b0;
      tx <= 1'b1;
      snap <= 32'd0;
      char_idx <= 4'd0;
      bit_idx <= 4'd0;
      baud <= '0;
    end else begin
      state <= state_n;
      reg_sel <= sel_n;
      busy <= busy_n;
      done <= done_n;
      tx <= tx_n;
      snap <= snap_n;
      char_idx <= char_n;
      bit_idx <= bit_n;
      baud <= baud_n;
    end
  end
endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: directed checks of reg_dump_tx with a mid-bit sampling UART receiver model.
module tb_reg_dump_tx;
  localparam int CPB = 4;
  localparam int N = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tgl = 1'b0;
  logic [31:0] rd = 32'd0;
  logic [31:0] r [N];
  logic [31:0] reg_data;
  logic [4:0] reg_sel;
  logic tx, busy, done;
  int checks = 0, failures = 0, busy_cnt = 0, done_cnt = 0, falls = 0, frame_err = 0, n = 0, bad = 0;
  logic [7:0] rxq [$];
  logic [7:0] r10_exp [10] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] t6_exp [10] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
  always #5 clk = ~clk;
  assign reg_data = tgl ? rd : r[reg_sel];
  reg_dump_tx #(.CLKS_PER_BIT(CPB), .NREGS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_data(reg_data),
    .reg_sel(reg_sel), .tx(tx), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] rxb(input int i);
    return i < rxq.size() ? rxq[i] : 8'hxx;
  endfunction
  function automatic logic [7:0] exp_byte(input logic [31:0] v, input int c);
    int nib;
    if (c == 8) return 8'h0D;
    if (c == 9) return 8'h0A;
    nib = int'((v >> (28 - 4 * c)) & 32'hF);
    return nib < 10 ? 8'(48 + nib) : 8'(65 + nib - 10);
  endfunction
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end
  always @(negedge tx) falls++;
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) frame_err++;
      rxq.push_back(b);
    end
  end
  task automatic run_dump(input int p1, input int p2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 13000) begin
      start = (n == p1 || n == p2);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("dump_timeout", 32'(n < 13000), 32'd1);
  endtask
  initial begin
    for (int i = 0; i < N; i++) r[i] = i;
    r[10] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", reg_sel, 0);
    rst = 1'b0;
    falls = 0;
    repeat (100) @(negedge clk);
    check("idle_falls", falls, 0);
    check("idle_tx", tx, 1);
    rxq.delete();
    busy_cnt = 0;
    done_cnt = 0;
    frame_err = 0;
    run_dump(-1, -1);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_sel", reg_sel, 0);
    check("busy_cycles", busy_cnt, 32'd12832);
    repeat (5) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("done_low", done, 0);
    check("byte_count", rxq.size(), 320);
    check("frame_err", frame_err, 0);
    for (int c = 0; c < 10; c++) check("r0_byte", rxb(c), c < 8 ? 32'h30 : c == 8 ? 32'h0D : 32'h0A);
    for (int c = 0; c < 10; c++) check("r10_byte", rxb(100 + c), r10_exp[c]);
    bad = 0;
    for (int i = 0; i < 320; i++) if (rxb(i) !== exp_byte(i / 10, i % 10) && i / 10 != 10) bad++;
    check("all_bytes", bad, 0);
    rxq.delete();
    busy_cnt = 0;
    done_cnt = 0;
    run_dump(50, 6000);
    check("t4_busy_cycles", busy_cnt, 32'd12832);
    check("t4_byte_count", rxq.size(), 320);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_tx_cap", tx, 1);
    @(negedge clk);
    check("restart_tx_low", tx, 0);
    repeat (7 * 401 + 214 - 1) @(negedge clk);
    check("mid_sel", reg_sel, 7);
    check("mid_tx_bit", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_sel", reg_sel, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    rxq.delete();
    falls = 0;
    repeat (200) @(negedge clk);
    check("abort_falls", falls, 0);
    check("abort_tx_hold", tx, 1);
    tgl = 1'b1;
    rd = 32'hAAAAAAAA;
    frame_err = 0;
    @(negedge clk);
    start = 1'b1;
    rd = 32'h55555555;
    @(negedge clk);
    start = 1'b0;
    rd = 32'h0123ABCD;
    for (int k = 0; k < 420; k++) begin
      @(negedge clk);
      rd = k[0] ? 32'h55555555 : 32'hAAAAAAAA;
    end
    for (int c = 0; c < 10; c++) check("snap_byte", rxb(c), t6_exp[c]);
    check("snap_frame_err", frame_err, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
